// File: rtl/serial_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_if
//  Description : Request/result bundle for the bit-serial adder.
//                master drives the operands and start, slave returns status
//                and the registered result.
//  Signals     : start      request to begin an addition
//                a, b       WIDTH-bit operands
//                cin        carry-in
//                busy       high while bits are being added
//                done       one-cycle result-valid strobe
//                sum        WIDTH-bit registered sum
//                cout       registered carry-out
//  Revision    : 1.0  initial release
// ============================================================================
interface serial_adder_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial adder, {cout,sum} = a + b + cin. One full-adder
//                cell and a carry flop process one bit per clock, LSB first.
//                One result every WIDTH+2 cycles (accept, WIDTH bits, DONE).
//  Ports       : clk    clock, all state changes on the rising edge
//                rst_n  synchronous active-low reset
//                bus    serial_adder_if.slave (start/a/b/cin in,
//                       busy/done/sum/cout out)
//  Parameters  : WIDTH  operand width in bits, WIDTH >= 1
//  Revision    : 1.0  initial release
// ============================================================================
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);

  localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] a_sh_q,  a_sh_d;
  logic [WIDTH-1:0] b_sh_q,  b_sh_d;
  logic [WIDTH-1:0] res_q,   res_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             carry_q, carry_d;
  logic             cout_q,  cout_d;

  logic             fa_s;
  logic             fa_c;
  logic             last_bit;
  logic [WIDTH-1:0] res_shift;
  logic             busy_w;
  logic             done_w;

  // --------------------------------------------------------------------------
  // Full-adder cell on the operand LSBs and the carry flop
  // --------------------------------------------------------------------------
  assign fa_s     = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign fa_c     = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
  assign last_bit = (cnt_q == LAST_BIT);

  // Sum bits enter from the MSB side so that after WIDTH shifts the first
  // (LSB) bit has reached position 0.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_shift = fa_s;
    end else begin : g_res_wn
      assign res_shift = {fa_s, res_q[WIDTH-1:1]};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic; start is only looked at in IDLE
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_BUSY;
      S_BUSY:  if (last_bit)  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs decoded from the state flop, so busy/done are mutually
  // exclusive and glitch-free
  // --------------------------------------------------------------------------
  always_comb begin
    busy_w = 1'b0;
    done_w = 1'b0;
    case (state_q)
      S_BUSY:  busy_w = 1'b1;
      S_DONE:  done_w = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy = busy_w;
  assign bus.done = done_w;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

  // --------------------------------------------------------------------------
  // Datapath next-state
  // --------------------------------------------------------------------------
  always_comb begin
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          // Operands and carry are snapshotted here; later input changes
          // cannot disturb the operation in flight.
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          res_d   = '0;
        end
      end
      S_BUSY: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = fa_c;
        res_d   = res_shift;
        cnt_d   = cnt_q + CNT_W'(1);
        // Visible result only changes when the final bit is in.
        if (last_bit) begin
          sum_d  = res_shift;
          cout_d = fa_c;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Directed self-checking bench for serial_adder. Three
//                instances (WIDTH 8, 4 and 1) share clock and reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_adder;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(4)) bus4 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_adder #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  serial_adder #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] opa(int j);
    return 8'(j * 37 + 11);
  endfunction
  function automatic logic [7:0] opb(int j);
    return 8'(j * 91 + 3);
  endfunction
  function automatic logic opc(int j);
    return ((j % 2) == 1);
  endfunction

  // Drives one WIDTH=8 operation and waits (bounded) for done.
  // lat = edges after the accept edge until done is seen, -1 on timeout.
  // held = 0 if sum/cout moved before done.
  task automatic do_op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                        input logic wait_idle,
                        output logic [7:0] os, output logic oc,
                        output int lat, output logic held);
    logic [7:0] s0;
    logic       c0;
    if (wait_idle) begin
      @(posedge clk); #1;
    end
    s0 = bus8.sum;
    c0 = bus8.cout;
    held = 1'b1;
    bus8.a = ia; bus8.b = ib; bus8.cin = ic; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    bus8.a = ~ia; bus8.b = ~ib; bus8.cin = ~ic;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (bus8.done) begin
        lat = n;
        break;
      end
      if (bus8.sum !== s0 || bus8.cout !== c0) held = 1'b0;
    end
    os = bus8.sum;
    oc = bus8.cout;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
      bad++; $display("FAIL reset_flags: busy=%b done=%b want 0 0", bus8.busy, bus8.done);
    end
    total++;
    if (bus8.sum !== 8'h00 || bus8.cout !== 1'b0) begin
      bad++; $display("FAIL reset_result: sum=%h cout=%b want 00 0", bus8.sum, bus8.cout);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ff_01;
    int bad_cyc;
    @(posedge clk); #1;
    bus8.a = 8'hFF; bus8.b = 8'h01; bus8.cin = 1'b0; bus8.start = 1'b1;
    @(posedge clk); #1;              // edge k
    bus8.start = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00;
    total++;
    if (bus8.busy !== 1'b1 || bus8.done !== 1'b0) begin
      bad++; $display("FAIL ff01_accept: busy=%b done=%b want 1 0", bus8.busy, bus8.done);
    end
    bad_cyc = 0;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
      if (bus8.busy !== 1'b1 || bus8.done !== 1'b0) bad_cyc++;
    end
    total++;
    if (bad_cyc != 0) begin
      bad++; $display("FAIL ff01_busy_window: bad cycles=%0d want 0", bad_cyc);
    end
    @(posedge clk); #1;              // edge k+8
    total++;
    if (bus8.done !== 1'b1 || bus8.busy !== 1'b0) begin
      bad++; $display("FAIL ff01_done: done=%b busy=%b want 1 0", bus8.done, bus8.busy);
    end
    total++;
    if (bus8.sum !== 8'h00 || bus8.cout !== 1'b1) begin
      bad++; $display("FAIL ff01_result: sum=%h cout=%b want 00 1", bus8.sum, bus8.cout);
    end
    @(posedge clk); #1;              // edge k+9
    total++;
    if (bus8.done !== 1'b0 || bus8.busy !== 1'b0 || bus8.sum !== 8'h00 || bus8.cout !== 1'b1) begin
      bad++; $display("FAIL ff01_after: done=%b busy=%b sum=%h cout=%b want 0 0 00 1",
                      bus8.done, bus8.busy, bus8.sum, bus8.cout);
    end
  endtask

  task automatic test_vectors;
    logic [7:0] s;
    logic       c;
    int         lat;
    logic       held;

    do_op8(8'hA5, 8'h5A, 1'b1, 1'b1, s, c, lat, held);
    total++;
    if (lat != 8 || s !== 8'h00 || c !== 1'b1) begin
      bad++; $display("FAIL vec_a5_5a_1: lat=%0d sum=%h cout=%b want 8 00 1", lat, s, c);
    end

    do_op8(8'h3C, 8'h0F, 1'b0, 1'b1, s, c, lat, held);
    total++;
    if (lat != 8 || s !== 8'h4B || c !== 1'b0) begin
      bad++; $display("FAIL vec_3c_0f_0: lat=%0d sum=%h cout=%b want 8 4b 0", lat, s, c);
    end
    total++;
    if (held !== 1'b1) begin
      bad++; $display("FAIL vec_hold_00: held=%b want 1", held);
    end

    do_op8(8'h7F, 8'h80, 1'b1, 1'b1, s, c, lat, held);
    total++;
    if (lat != 8 || s !== 8'h00 || c !== 1'b1 || held !== 1'b1) begin
      bad++; $display("FAIL vec_7f_80_1: lat=%0d sum=%h cout=%b held=%b want 8 00 1 1", lat, s, c, held);
    end

    // Previous op ended with carry 1; this one must start from cin=0.
    do_op8(8'h01, 8'h01, 1'b0, 1'b1, s, c, lat, held);
    total++;
    if (lat != 8 || s !== 8'h02 || c !== 1'b0) begin
      bad++; $display("FAIL vec_carry_reload: lat=%0d sum=%h cout=%b want 8 02 0", lat, s, c);
    end

    do_op8(8'h3C, 8'h0F, 1'b1, 1'b1, s, c, lat, held);
    total++;
    if (lat != 8 || s !== 8'h4C || c !== 1'b0) begin
      bad++; $display("FAIL vec_3c_0f_1: lat=%0d sum=%h cout=%b want 8 4c 0", lat, s, c);
    end
  endtask

  task automatic test_start_held;
    int         acc[$];
    int         done_cnt;
    int         overlap;
    logic       prev_busy;
    logic [8:0] exp;
    @(posedge clk); #1;
    prev_busy = bus8.busy;
    done_cnt = 0;
    overlap = 0;
    bus8.a = opa(0); bus8.b = opb(0); bus8.cin = opc(0); bus8.start = 1'b1;
    for (int j = 0; j < 30; j++) begin
      @(posedge clk); #1;
      if (bus8.busy && bus8.done) overlap++;
      if (bus8.busy && !prev_busy) acc.push_back(j);
      if (bus8.done) begin
        done_cnt++;
        if (j >= 8) begin
          exp = 9'(opa(j - 8)) + 9'(opb(j - 8)) + 9'(opc(j - 8));
          total++;
          if ({bus8.cout, bus8.sum} !== exp) begin
            bad++; $display("FAIL held_result@%0d: got=%h want=%h", j, {bus8.cout, bus8.sum}, exp);
          end
        end
      end
      prev_busy = bus8.busy;
      bus8.a = opa(j + 1); bus8.b = opb(j + 1); bus8.cin = opc(j + 1);
    end
    bus8.start = 1'b0;
    total++;
    if (acc.size() != 3 || acc[0] != 0 || acc[1] != 10 || acc[2] != 20) begin
      bad++; $display("FAIL held_accepts: count=%0d want 3 at 0,10,20", acc.size());
    end
    total++;
    if (done_cnt != 3) begin
      bad++; $display("FAIL held_done_count: got=%0d want 3", done_cnt);
    end
    total++;
    if (overlap != 0) begin
      bad++; $display("FAIL busy_done_overlap: cycles=%0d want 0", overlap);
    end
  endtask

  task automatic test_reset_mid_busy;
    logic [7:0] s;
    logic       c;
    int         lat;
    logic       held;
    @(posedge clk); #1;
    bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.cin = 1'b1; bus8.start = 1'b1;
    @(posedge clk); #1;              // edge k
    bus8.start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;              // edge k+4, 4th bit cycle
    total++;
    if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.sum !== 8'h00 || bus8.cout !== 1'b0) begin
      bad++; $display("FAIL midreset_outputs: busy=%b done=%b sum=%h cout=%b want 0 0 00 0",
                      bus8.busy, bus8.done, bus8.sum, bus8.cout);
    end
    // Accept on the very first released edge; any leftover done from the
    // aborted operation would show up as an early latency.
    rst_n = 1'b1;
    do_op8(8'h80, 8'h80, 1'b0, 1'b0, s, c, lat, held);
    total++;
    if (lat != 8 || s !== 8'h00 || c !== 1'b1 || held !== 1'b1) begin
      bad++; $display("FAIL midreset_next: lat=%0d sum=%h cout=%b held=%b want 8 00 1 1", lat, s, c, held);
    end
  endtask

  task automatic test_w4_exhaustive;
    int         n;
    int         extra;
    logic [4:0] exp;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          @(posedge clk); #1;
          bus4.a = 4'(ia); bus4.b = 4'(ib); bus4.cin = 1'(ic); bus4.start = 1'b1;
          @(posedge clk); #1;
          bus4.start = 1'b0; bus4.a = 4'(~ia); bus4.b = 4'(~ib);
          n = 0;
          while (bus4.done !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
          end
          exp = 5'(ia + ib + ic);
          total++;
          if (n != 4 || {bus4.cout, bus4.sum} !== exp) begin
            bad++; $display("FAIL w4 %0d+%0d+%0d: lat=%0d got=%h want lat 4 val %h",
                            ia, ib, ic, n, {bus4.cout, bus4.sum}, exp);
          end
          @(posedge clk); #1;
          extra = bus4.done ? 1 : 0;
          total++;
          if (extra != 0 || bus4.busy !== 1'b0) begin
            bad++; $display("FAIL w4_single_done %0d+%0d+%0d: done=%b busy=%b want 0 0",
                            ia, ib, ic, bus4.done, bus4.busy);
          end
        end
      end
    end
  endtask

  task automatic test_w1;
    logic [1:0] exp;
    for (int ia = 0; ia < 2; ia++) begin
      for (int ib = 0; ib < 2; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          @(posedge clk); #1;
          @(posedge clk); #1;
          bus1.a = 1'(ia); bus1.b = 1'(ib); bus1.cin = 1'(ic); bus1.start = 1'b1;
          @(posedge clk); #1;        // accept
          bus1.start = 1'b0;
          total++;
          if (bus1.busy !== 1'b1 || bus1.done !== 1'b0) begin
            bad++; $display("FAIL w1_accept %0d%0d%0d: busy=%b done=%b want 1 0",
                            ia, ib, ic, bus1.busy, bus1.done);
          end
          @(posedge clk); #1;        // k+1
          exp = 2'(ia + ib + ic);
          total++;
          if (bus1.done !== 1'b1 || {bus1.cout, bus1.sum} !== exp) begin
            bad++; $display("FAIL w1_result %0d%0d%0d: done=%b got=%b want done 1 val %b",
                            ia, ib, ic, bus1.done, {bus1.cout, bus1.sum}, exp);
          end
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;

    test_reset();
    test_ff_01();
    test_vectors();
    test_start_held();
    test_reset_mid_busy();
    test_w4_exhaustive();
    test_w1();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
